// File: rtl/sbd_fifo_mw.sv
// -----------------------------------------------------------------------------
// sbd_fifo_mw
//
// Multi-lane in-order scoreboard FIFO. The issue stage pushes the pipeline tag
// (pl) of every issued instruction, and the commit stage releases tags in
// program order. Up to NLanes entries can be pushed and popped per cycle.
//
// Optional feature macro: SBD_FIFO_PC_EN
//   When defined, a 32-bit PC is stored with every entry, and the wr_pc_i and
//   rd_pc_o ports exist. When it is undefined, those ports are absent and the
//   storage holds only pl.
//
// Handshake (both sides, per lane k):
//   Push: lane k is accepted when wr_en_i[k] and wr_rdy_o[k] are both high in
//   the same cycle. Pop: lane k is accepted when rd_ack_i[k] and rd_valid_o[k]
//   are both high in the same cycle. Requests must be thermometer-coded
//   (lane 0 first). Ready and valid depend only on registered state and never
//   on the same-cycle request.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   flush_i     synchronous flush; empties the FIFO and clears err_o
//   wr_en_i     push request per lane
//   wr_pl_i     tag per push lane
//   wr_pc_i     PC per push lane            (SBD_FIFO_PC_EN only)
//   wr_rdy_o    wr_rdy_o[k] = (free >= k+1)
//   rd_valid_o  rd_valid_o[k] = (count > k)
//   rd_pl_o     tag of entry head+k, 0 when the lane is not valid
//   rd_pc_o     PC of entry head+k, 0 when the lane is not valid (SBD_FIFO_PC_EN only)
//   rd_ack_i    pop per lane
//   count_o     number of occupied entries
//   err_o       sticky protocol error (overflow, underflow, non-thermometer)
// -----------------------------------------------------------------------------
module sbd_fifo_mw #(
  parameter int Depth  = 8,
  parameter int NLanes = 2,
  parameter int PlW    = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [NLanes-1:0]          wr_en_i,
  input  logic [NLanes*PlW-1:0]      wr_pl_i,
`ifdef SBD_FIFO_PC_EN
  input  logic [NLanes*32-1:0]       wr_pc_i,
`endif
  output logic [NLanes-1:0]          wr_rdy_o,
  output logic [NLanes-1:0]          rd_valid_o,
  output logic [NLanes*PlW-1:0]      rd_pl_o,
`ifdef SBD_FIFO_PC_EN
  output logic [NLanes*32-1:0]       rd_pc_o,
`endif
  input  logic [NLanes-1:0]          rd_ack_i,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       err_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  // Elaboration-time parameter sanity checks.
  if (Depth < 4 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("sbd_fifo_mw: Depth must be a power of 2 and at least 4");
  end
  if (NLanes < 1 || NLanes > 4 || NLanes > Depth) begin : g_bad_lanes
    $error("sbd_fifo_mw: NLanes must be in 1..4 and not exceed Depth");
  end

  // Number of set bits in a lane mask.
  function automatic logic [CW-1:0] popcnt(input logic [NLanes-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NLanes; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  // A mask is thermometer-coded when its set bits are contiguous from lane 0.
  // Adding one to such a mask clears every set bit, so the AND becomes zero.
  function automatic logic is_thermo(input logic [NLanes-1:0] v);
    logic [NLanes-1:0] inc;
    inc = v + NLanes'(1);
    return (v & inc) == '0;
  endfunction

  // State
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_err;
  logic [PlW-1:0] r_mem_pl [Depth];
`ifdef SBD_FIFO_PC_EN
  logic [31:0]    r_mem_pc [Depth];
`endif

  // Combinational views of the registered state
  logic [CW-1:0]     w_free;
  logic [NLanes-1:0] w_wr_rdy;
  logic [NLanes-1:0] w_rd_valid;
  logic [NLanes-1:0] w_acc_w;
  logic [NLanes-1:0] w_acc_r;
  logic [CW-1:0]     w_nw;
  logic [CW-1:0]     w_nr;
  logic              w_err_ev;

  assign w_free = CW'(Depth) - r_count;

  // Readiness is based on start-of-cycle occupancy only, so a same-cycle pop
  // never re-opens a push lane.
  always_comb begin
    w_wr_rdy   = '0;
    w_rd_valid = '0;
    for (int k = 0; k < NLanes; k++) begin
      w_wr_rdy[k]   = (w_free >= CW'(k + 1));
      w_rd_valid[k] = (r_count > CW'(k));
    end
  end

  assign w_acc_w = wr_en_i  & w_wr_rdy;
  assign w_acc_r = rd_ack_i & w_rd_valid;
  assign w_nw    = popcnt(w_acc_w);
  assign w_nr    = popcnt(w_acc_r);

  assign w_err_ev = (|(wr_en_i  & ~w_wr_rdy))   ||
                    (|(rd_ack_i & ~w_rd_valid)) ||
                    !is_thermo(wr_en_i)         ||
                    !is_thermo(rd_ack_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        r_mem_pl[i] <= '0;
`ifdef SBD_FIFO_PC_EN
        r_mem_pc[i] <= '0;
`endif
      end
    end else if (flush_i) begin
      // Flush wins over any push, pop or error in the same cycle.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      // Lane k lands at wptr+k; the AW-bit add wraps modulo Depth, so lane
      // order is kept when an access straddles the end of the array.
      for (int k = 0; k < NLanes; k++) begin
        if (w_acc_w[k]) begin
          r_mem_pl[r_wptr + AW'(k)] <= wr_pl_i[k*PlW +: PlW];
`ifdef SBD_FIFO_PC_EN
          r_mem_pc[r_wptr + AW'(k)] <= wr_pc_i[k*32 +: 32];
`endif
        end
      end
      r_wptr  <= r_wptr + AW'(w_nw);
      r_rptr  <= r_rptr + AW'(w_nr);
      r_count <= r_count + w_nw - w_nr;
      if (w_err_ev) begin
        r_err <= 1'b1;
      end
    end
  end

  // Read side: combinational view of the head entries, zeroed when invalid.
  always_comb begin
    rd_pl_o = '0;
`ifdef SBD_FIFO_PC_EN
    rd_pc_o = '0;
`endif
    for (int k = 0; k < NLanes; k++) begin
      if (w_rd_valid[k]) begin
        rd_pl_o[k*PlW +: PlW] = r_mem_pl[r_rptr + AW'(k)];
`ifdef SBD_FIFO_PC_EN
        rd_pc_o[k*32 +: 32]   = r_mem_pc[r_rptr + AW'(k)];
`endif
      end
    end
  end

  assign wr_rdy_o   = w_wr_rdy;
  assign rd_valid_o = w_rd_valid;
  assign count_o    = r_count;
  assign err_o      = r_err;

`ifndef SYNTHESIS
  // Non-thermometer requests are still handled (masked) but flag a bug in the
  // driving stage.
  a_wr_thermo : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 is_thermo(wr_en_i));
  a_rd_thermo : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 is_thermo(rd_ack_i));
`endif

endmodule

// File: tb/tb_sbd_fifo_mw.sv
// -----------------------------------------------------------------------------
// tb_sbd_fifo_mw
//
// Directed self-checking bench for sbd_fifo_mw (Depth=8, NLanes=2, PlW=5).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point,
// where they reflect the state produced by that edge.
// -----------------------------------------------------------------------------
module tb_sbd_fifo_mw;

  localparam int Depth  = 8;
  localparam int NLanes = 2;
  localparam int PlW    = 5;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic                  flush  = 1'b0;
  logic [NLanes-1:0]     wr_en  = '0;
  logic [NLanes*PlW-1:0] wr_pl  = '0;
  logic [NLanes-1:0]     rd_ack = '0;
  logic [NLanes-1:0]     wr_rdy;
  logic [NLanes-1:0]     rd_valid;
  logic [NLanes*PlW-1:0] rd_pl;
  logic [3:0]            count;
  logic                  err;
`ifdef SBD_FIFO_PC_EN
  logic [NLanes*32-1:0]  wr_pc = '0;
  logic [NLanes*32-1:0]  rd_pc;
`endif

  int checks   = 0;
  int failures = 0;
  logic [PlW-1:0] exp_q[$];

  sbd_fifo_mw #(.Depth(Depth), .NLanes(NLanes), .PlW(PlW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .wr_en_i    (wr_en),
    .wr_pl_i    (wr_pl),
`ifdef SBD_FIFO_PC_EN
    .wr_pc_i    (wr_pc),
`endif
    .wr_rdy_o   (wr_rdy),
    .rd_valid_o (rd_valid),
    .rd_pl_o    (rd_pl),
`ifdef SBD_FIFO_PC_EN
    .rd_pc_o    (rd_pc),
`endif
    .rd_ack_i   (rd_ack),
    .count_o    (count),
    .err_o      (err)
  );

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] en, input logic [4:0] p0,
                       input logic [4:0] p1, input logic [1:0] ack,
                       input logic fl);
    wr_en  = en;
    wr_pl  = {p1, p0};
    rd_ack = ack;
    flush  = fl;
  endtask

  task automatic idle();
    drive(2'b00, 5'd0, 5'd0, 2'b00, 1'b0);
  endtask

  // Reset values appear without any clock edge
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (wr_rdy !== 2'b11) begin failures++; $display("FAIL reset_wr_rdy got=%b exp=%b", wr_rdy, 2'b11); end
    checks++; if (rd_valid !== 2'b00) begin failures++; $display("FAIL reset_rd_valid got=%b exp=%b", rd_valid, 2'b00); end
    checks++; if (rd_pl !== 10'd0) begin failures++; $display("FAIL reset_rd_pl got=%h exp=%h", rd_pl, 10'd0); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=%0d", count, 0); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=%b", err, 1'b0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL post_reset_count got=%0d exp=%0d", count, 0); end
  endtask

  // Fill with 1,2 / 3,4 / 5,6 / 7,8
  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 5'(2*i + 1), 5'(2*i + 2), 2'b00, 1'b0);
      step();
      checks++; if (count !== 4'(2*(i + 1))) begin failures++; $display("FAIL fill_count_%0d got=%0d exp=%0d", i, count, 2*(i + 1)); end
    end
    idle();
    checks++; if (wr_rdy !== 2'b00) begin failures++; $display("FAIL fill_wr_rdy got=%b exp=%b", wr_rdy, 2'b00); end
    checks++; if (rd_valid !== 2'b11) begin failures++; $display("FAIL fill_rd_valid got=%b exp=%b", rd_valid, 2'b11); end
    checks++; if (rd_pl !== {5'd2, 5'd1}) begin failures++; $display("FAIL fill_rd_pl got=%h exp=%h", rd_pl, {5'd2, 5'd1}); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL fill_err got=%b exp=%b", err, 1'b0); end
  endtask

  // Full: push and pop together; the push is dropped
  task automatic test_full_pop();
    drive(2'b11, 5'd30, 5'd31, 2'b11, 1'b0);
    step();
    idle();
    checks++; if (count !== 4'd6) begin failures++; $display("FAIL fullpop_count got=%0d exp=%0d", count, 6); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL fullpop_err got=%b exp=%b", err, 1'b1); end
    checks++; if (rd_pl !== {5'd4, 5'd3}) begin failures++; $display("FAIL fullpop_rd_pl got=%h exp=%h", rd_pl, {5'd4, 5'd3}); end
    checks++; if (wr_rdy !== 2'b11) begin failures++; $display("FAIL fullpop_wr_rdy got=%b exp=%b", wr_rdy, 2'b11); end
  endtask

  // At count=7 only lane 0 of a two-lane push gets in
  task automatic test_partial();
    logic [4:0] seq [8];
    seq = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd9};
    drive(2'b00, 5'd0, 5'd0, 2'b00, 1'b1);
    step();
    idle();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL flush1_count got=%0d exp=%0d", count, 0); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL flush1_err got=%b exp=%b", err, 1'b0); end
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, seq[2*i], seq[2*i + 1], 2'b00, 1'b0);
      step();
    end
    drive(2'b01, seq[6], 5'd0, 2'b00, 1'b0);
    step();
    idle();
    checks++; if (count !== 4'd7) begin failures++; $display("FAIL partial_count7 got=%0d exp=%0d", count, 7); end
    checks++; if (wr_rdy !== 2'b01) begin failures++; $display("FAIL partial_wr_rdy got=%b exp=%b", wr_rdy, 2'b01); end
    drive(2'b11, 5'd9, 5'd10, 2'b00, 1'b0);
    step();
    idle();
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL partial_count8 got=%0d exp=%0d", count, 8); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL partial_err got=%b exp=%b", err, 1'b1); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (rd_pl !== {seq[2*j + 1], seq[2*j]}) begin failures++; $display("FAIL partial_drain_%0d got=%h exp=%h", j, rd_pl, {seq[2*j + 1], seq[2*j]}); end
      drive(2'b00, 5'd0, 5'd0, 2'b11, 1'b0);
      step();
    end
    idle();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL partial_empty got=%0d exp=%0d", count, 0); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL partial_err_sticky got=%b exp=%b", err, 1'b1); end
  endtask

  // 20 entries with odd pointer offsets so accesses straddle 7 -> 0
  task automatic test_wrap();
    int pushed, popped, m_cnt, cyc, nw, nr;
    logic [1:0] en, ack;
    logic [4:0] p0, p1, exp_v;
    drive(2'b00, 5'd0, 5'd0, 2'b00, 1'b1);
    step();
    idle();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wrap_flush_err got=%b exp=%b", err, 1'b0); end
    exp_q.delete();
    pushed = 0; popped = 0; m_cnt = 0; cyc = 0;
    while (popped < 20 && cyc < 60) begin
      en = 2'b00; nw = 0; p0 = 5'd0; p1 = 5'd0;
      if (cyc == 1 || (20 - pushed) == 1) begin
        en = 2'b01; nw = 1;
      end else if ((20 - pushed) >= 2 && m_cnt <= 6) begin
        en = 2'b11; nw = 2;
      end
      ack = 2'b00; nr = 0;
      if (cyc == 2) begin
        ack = 2'b01; nr = 1;
      end else if (cyc > 2 && m_cnt >= 2) begin
        ack = 2'b11; nr = 2;
      end else if (cyc > 2 && m_cnt == 1) begin
        ack = 2'b01; nr = 1;
      end
      checks++; if (count !== 4'(m_cnt)) begin failures++; $display("FAIL wrap_count_c%0d got=%0d exp=%0d", cyc, count, m_cnt); end
      for (int k = 0; k < nr; k++) begin
        exp_v = exp_q.pop_front();
        checks++; if (rd_pl[k*PlW +: PlW] !== exp_v) begin failures++; $display("FAIL wrap_pl_c%0d_l%0d got=%0d exp=%0d", cyc, k, rd_pl[k*PlW +: PlW], exp_v); end
        popped++;
      end
      if (nw >= 1) begin p0 = 5'(pushed + 1); exp_q.push_back(p0); end
      if (nw == 2) begin p1 = 5'(pushed + 2); exp_q.push_back(p1); end
      pushed = pushed + nw;
      m_cnt  = m_cnt + nw - nr;
      drive(en, p0, p1, ack, 1'b0);
      step();
      cyc++;
    end
    idle();
    checks++; if (popped != 20) begin failures++; $display("FAIL wrap_popped got=%0d exp=%0d", popped, 20); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL wrap_final_count got=%0d exp=%0d", count, 0); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wrap_err got=%b exp=%b", err, 1'b0); end
  endtask

  // Two-lane pop with only one entry present
  task automatic test_underflow();
    drive(2'b01, 5'd17, 5'd0, 2'b00, 1'b0);
    step();
    idle();
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL under_count1 got=%0d exp=%0d", count, 1); end
    checks++; if (rd_valid !== 2'b01) begin failures++; $display("FAIL under_valid1 got=%b exp=%b", rd_valid, 2'b01); end
    checks++; if (rd_pl !== {5'd0, 5'd17}) begin failures++; $display("FAIL under_rd_pl1 got=%h exp=%h", rd_pl, {5'd0, 5'd17}); end
    drive(2'b00, 5'd0, 5'd0, 2'b11, 1'b0);
    step();
    idle();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL under_count0 got=%0d exp=%0d", count, 0); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL under_err got=%b exp=%b", err, 1'b1); end
    checks++; if (rd_valid !== 2'b00) begin failures++; $display("FAIL under_valid0 got=%b exp=%b", rd_valid, 2'b00); end
    checks++; if (rd_pl !== 10'd0) begin failures++; $display("FAIL under_rd_pl0 got=%h exp=%h", rd_pl, 10'd0); end
  endtask

  // Flush beats a same-cycle push; async reset mid-cycle
  task automatic test_flush_reset();
    drive(2'b11, 5'd11, 5'd12, 2'b00, 1'b0); step();
    drive(2'b11, 5'd13, 5'd14, 2'b00, 1'b0); step();
    drive(2'b01, 5'd15, 5'd0,  2'b00, 1'b0); step();
    idle();
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL fr_count5 got=%0d exp=%0d", count, 5); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL fr_err_before got=%b exp=%b", err, 1'b1); end
    drive(2'b11, 5'd1, 5'd2, 2'b00, 1'b1);
    step();
    idle();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL fr_flush_count got=%0d exp=%0d", count, 0); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL fr_flush_err got=%b exp=%b", err, 1'b0); end
    checks++; if (rd_valid !== 2'b00) begin failures++; $display("FAIL fr_flush_valid got=%b exp=%b", rd_valid, 2'b00); end
    drive(2'b11, 5'd3, 5'd4, 2'b00, 1'b0);
    step();
    idle();
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL fr_count2 got=%0d exp=%0d", count, 2); end
    checks++; if (rd_pl !== {5'd4, 5'd3}) begin failures++; $display("FAIL fr_rd_pl got=%h exp=%h", rd_pl, {5'd4, 5'd3}); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL arst_count got=%0d exp=%0d", count, 0); end
    checks++; if (rd_valid !== 2'b00) begin failures++; $display("FAIL arst_valid got=%b exp=%b", rd_valid, 2'b00); end
    checks++; if (rd_pl !== 10'd0) begin failures++; $display("FAIL arst_rd_pl got=%h exp=%h", rd_pl, 10'd0); end
    checks++; if (wr_rdy !== 2'b11) begin failures++; $display("FAIL arst_wr_rdy got=%b exp=%b", wr_rdy, 2'b11); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL arst_err got=%b exp=%b", err, 1'b0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL arst_after_count got=%0d exp=%0d", count, 0); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_partial();
    test_wrap();
    test_underflow();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the whole run is a few hundred cycles
  initial begin
    #50000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sbd_fifo_mw.md
# sbd_fifo_mw

Multi-lane in-order scoreboard FIFO that records the pipeline tag (`pl`) of every issued instruction and releases tags in program order at commit. It is the parametrised successor of the fixed two-wide `sbd_fifo_t` queue: it supports N issue/commit lanes, configurable depth, per-lane ready signalling and flush. It also flags illegal pushes and pops with a sticky error. It sits between the issue stage (push side) and the commit stage (pop side).

## Interface
Parameters:
- `Depth`, 8: number of entries; must be a power of 2 and at least 4.
- `NLanes`, 2: push/pop lanes per cycle; range 1..4; must satisfy `NLanes <= Depth`.
- `PlW`, 5: width of the `pl` tag in bits.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  synchronous flush; clears the FIFO.
- `wr_en_i`  in  NLanes  push request per lane; must be thermometer-coded (lane 0 first).
- `wr_pl_i`  in  NLanes*PlW  tag per push lane.
- `wr_pc_i`  in  NLanes*32  PC per push lane; present only with `SBD_FIFO_PC_EN`.
- `wr_rdy_o`  out  NLanes  `wr_rdy_o[k] = (free >= k+1)`.
- `rd_valid_o`  out  NLanes  `rd_valid_o[k] = (count > k)`.
- `rd_pl_o`  out  NLanes*PlW  tag of entry head+k.
- `rd_pc_o`  out  NLanes*32  PC of entry head+k; present only with `SBD_FIFO_PC_EN`.
- `rd_ack_i`  in  NLanes  pop per lane; must be thermometer-coded.
- `count_o`  out  $clog2(Depth)+1  number of occupied entries.
- `err_o`  out  1  sticky protocol error.

## Operation
State:
- `wptr` and `rptr` are each $clog2(Depth) bits and wrap modulo Depth.
- `count` ranges 0..Depth; `free = Depth - count`.
- Storage is an array of Depth entries, each holding `{pl[, pc]}`.

Push:
- Accepted lanes are `acc_w = wr_en_i & wr_rdy_o`.
- Lane k writes `mem[wptr+k]`.
- `wptr` advances by popcount(`acc_w`).

Pop:
- Accepted lanes are `acc_r = rd_ack_i & rd_valid_o`.
- `rptr` advances by popcount(`acc_r`).

Simultaneous push and pop:
- `count' = count + nw - nr`.
- Readiness is computed from `free` at the start of the cycle. Slots freed by a same-cycle pop are not reusable until the next cycle.

Read side:
- `rd_*_o` are combinational reads of `mem[rptr+k]`.
- When `rd_valid_o[k]=0`, the corresponding `rd_pl_o` and `rd_pc_o` lanes drive 0.
- There is no bypass: a pushed entry becomes readable the cycle after the push.

Flush:
- Sets `wptr`, `rptr` and `count` to 0 and clears `err_o`.
- Has priority over any same-cycle push, pop or error event.

Errors (`err_o` set next cycle, held until flush or reset):
- `wr_en_i` has a lane set with `wr_rdy_o` low (overflow attempt). The offending lane is dropped; lower lanes are still accepted.
- `rd_ack_i` has a lane set with `rd_valid_o` low (underflow attempt). That lane is ignored.
- `wr_en_i` or `rd_ack_i` is not thermometer-coded. The whole request is still processed masked as above, and a simulation assertion fires.

Reset (`rst_ni` low, asynchronous):
- Pointers, count, `err_o` and storage go to 0.
- Outputs during and after reset: `wr_rdy_o` all ones, `rd_valid_o` 0, `rd_pl_o` 0, `rd_pc_o` 0, `count_o` 0, `err_o` 0.
- A reset asserted mid-operation discards all entries immediately.

## Timing
- Push-to-visible latency: 1 cycle. Pop takes effect at the clock edge.
- All state is updated on the rising edge of `clk_i`.
- `wr_rdy_o`, `rd_valid_o` and `count_o` are registered-state functions. There is no combinational path from `wr_en_i` or `rd_ack_i` to any output.
- Full (`count == Depth`): `wr_rdy_o` is all zeros, and a pop in the same cycle does not re-open any lane that cycle.
- Empty: `rd_valid_o` is all zeros.
- Pointer wrap: a multi-lane access may straddle index Depth-1 → 0, and lane ordering must be preserved across the wrap.

## Configuration
- `SBD_FIFO_PC_EN` defined: the 32-bit PC is stored per entry, and the `wr_pc_i` and `rd_pc_o` ports exist. This is intended for simulation debug and trace.
- Macro not defined: the ports are removed and storage holds only `pl`. Behaviour is otherwise identical.

## Test plan
- **Reset and fill.** Reset, then push 2 lanes/cycle with `pl` = 1,2 / 3,4 / 5,6 / 7,8 (`Depth=8`, `NLanes=2`).
  - `count_o` reads 2, 4, 6, 8 on successive cycles.
  - After the fourth push, `wr_rdy_o=2'b00`.
  - `rd_pl_o` lane0=1, lane1=2.
- **Full with simultaneous pop.** At `count=8`, assert `rd_ack_i=2'b11` and `wr_en_i=2'b11` in the same cycle.
  - The push is dropped, `err_o`=1 next cycle, and `count_o`=6.
- **Partial readiness.** At `count=7`, assert `wr_en_i=2'b11` with `pl` = 9,10.
  - Lane 0 is accepted (`pl`=9) and lane 1 is dropped.
  - `count_o`=8 and `err_o`=1.
- **Wrap.** Cycle 20 entries through with pushes and pops straddling index 7→0.
  - Popped `pl` sequence equals the pushed sequence exactly, and `err_o` stays 0.
- **Underflow.** At `count=1`, assert `rd_ack_i=2'b11`.
  - `count_o`=0, `err_o`=1, and `rd_valid_o`=0.
- **Flush vs push and async reset.** Assert `flush_i` together with `wr_en_i=2'b11` at `count=5`.
  - Next cycle: `count_o`=0 and `err_o`=0.
  - Then drop `rst_ni` mid-cycle: outputs go to their reset values without waiting for a clock edge.
